// File: rtl/bcd_seq_addsub.sv
// Serial packed-BCD add/subtract: one digit per clock, LSD first, shared digit adder.
// Define BCD_SIGNMAG_EN for sign/magnitude subtraction (extra COMP pass, neg flag).
module bcd_seq_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
`ifdef BCD_SIGNMAG_EN
    , COMP = 2'd3
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    res_q;
  logic            cout_q, neg_q, err_q;

  logic            last;
  logic            bad_in;
  logic            in_comp;
  logic [3:0]      op_x, op_y;
  logic [4:0]      sum;
  logic [4:0]      sum_adj;
  logic            gt9;
  logic [3:0]      digit;

  function automatic logic has_bad(input logic [W-1:0] v);
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
  endfunction

  assign last   = (idx == IW'(DIGITS - 1));
  assign bad_in = has_bad(a) | has_bad(b);

`ifdef BCD_SIGNMAG_EN
  assign in_comp = (state == COMP);
`else
  assign in_comp = 1'b0;
`endif

  // COMP re-runs the adder as 9's complement of the raw result plus one
  always_comb begin
    op_x = a_q[{idx, 2'b00} +: 4];
    op_y = sub_q ? 4'd9 - b_q[{idx, 2'b00} +: 4]
                 : b_q[{idx, 2'b00} +: 4];
    if (in_comp) begin
      op_x = 4'd9 - res_q[{idx, 2'b00} +: 4];
      op_y = 4'd0;
    end
  end

  assign sum     = {1'b0, op_x} + {1'b0, op_y} + {4'd0, carry};
  assign sum_adj = sum + 5'd6;
  assign gt9     = (sum > 5'd9);
  assign digit   = gt9 ? sum_adj[3:0] : sum[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = bad_in ? DONE : RUN;
      RUN: begin
        if (last) begin
          state_nxt = DONE;
`ifdef BCD_SIGNMAG_EN
          if (sub_q && !gt9) state_nxt = COMP;
`endif
        end
      end
`ifdef BCD_SIGNMAG_EN
      COMP: if (last) state_nxt = DONE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            idx    <= '0;
            carry  <= sub;
            res_q  <= '0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= bad_in;
          end
        end
        RUN: begin
          res_q[{idx, 2'b00} +: 4] <= digit;
          carry <= gt9;
          idx   <= idx + 1'b1;
          if (last) begin
            idx    <= '0;
            cout_q <= gt9;
`ifdef BCD_SIGNMAG_EN
            if (sub_q && !gt9) carry <= 1'b1;
`endif
          end
        end
`ifdef BCD_SIGNMAG_EN
        COMP: begin
          res_q[{idx, 2'b00} +: 4] <= digit;
          carry <= gt9;
          idx   <= idx + 1'b1;
          if (last) begin
            idx    <= '0;
            neg_q  <= 1'b1;
            cout_q <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign busy   = (state == RUN) | in_comp;
  assign done   = (state == DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign neg    = neg_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_seq_addsub.sv
// Bench for bcd_seq_addsub: directed and random ops against an integer model.
// Honours BCD_SIGNMAG_EN when the design is built with it.
module tb_bcd_seq_addsub;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout, neg, err;
  logic [W-1:0] result;

  int total = 0;
  int passed = 0;

  bcd_seq_addsub #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
    .result(result), .cout(cout), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit bad_bcd(input logic [W-1:0] v);
    for (int i = 0; i < D; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // Plain decimal arithmetic model
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic ms, output logic [W-1:0] er,
                       output logic ec, output logic en, output logic ee,
                       output int lat);
    int lim = 1;
    int av, bv, v;
    for (int i = 0; i < D; i++) lim = lim * 10;
    er = '0; ec = 1'b0; en = 1'b0; ee = 1'b0; lat = D + 1;
    if (bad_bcd(ma) || bad_bcd(mb)) begin
      ee = 1'b1; lat = 1;
      return;
    end
    av = bcd2int(ma);
    bv = bcd2int(mb);
    if (!ms) begin
      v  = av + bv;
      ec = (v >= lim);
      er = int2bcd(v % lim);
    end else begin
      v = av - bv;
      if (v >= 0) begin
        ec = 1'b1;
        er = int2bcd(v);
      end else begin
`ifdef BCD_SIGNMAG_EN
        en  = 1'b1;
        er  = int2bcd(-v);
        lat = 2 * D + 1;
`else
        er = int2bcd(v + lim);
`endif
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic ts,
                        input int glitch);
    logic [W-1:0] er;
    logic ec, en, ee;
    int lat, cyc, g;
    model(ta, tb, ts, er, ec, en, ee, lat);
    g = 0;
    while (!ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".ready_in"}, 32'(ready), 32'd1);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == glitch) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".neg"}, 32'(neg), 32'(en));
    check({tag, ".err"}, 32'(err), 32'(ee));
    @(negedge clk);
    check({tag, ".ready_after"}, {30'd0, ready, done}, 32'h2);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int cyc;
    repeat (2) @(negedge clk);
    check("rst.flags", {25'd0, ready, busy, done, cout, neg, err, 1'b0},
          32'h40);
    check("rst.result", 32'(result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("s1", 16'h1234, 16'h5678, 1'b0, 0);
    check("s1.const", 32'(result), 32'h6912);
    run_op("s2", 16'h9999, 16'h0001, 1'b0, 0);
    run_op("s3", 16'h5000, 16'h1234, 1'b1, 0);
    run_op("s4", 16'h0100, 16'h0250, 1'b1, 0);
    run_op("s5e", 16'h00A1, 16'h0001, 1'b0, 0);
    run_op("s5v", 16'h1234, 16'h5678, 1'b0, 0);
    run_op("eq", 16'h4321, 16'h4321, 1'b1, 0);
    run_op("glitch", 16'h1234, 16'h5678, 1'b0, 2);

    // Reset in C3 aborts the op without a done pulse
    a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    check("abort.ready", {30'd0, ready, busy}, 32'h2);
    check("abort.result", 32'(result), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.nodone2", 32'(done), 32'd0);
    run_op("post_rst", 16'h1234, 16'h5678, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0)
        ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0)
        rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
